// File: rtl/demux32_pipeline.sv
// One-to-32 demultiplexer: an S1 input register feeds 32 single-entry port registers.
// Latency: 2 edges from upstream acceptance to valid_out[d] when port d is free.
// Backpressure: ready_out drops only when S1 is full and its destination port is full and stalled.
module demux32_pipeline #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [WIDTH-1:0]      data_in,
    input  logic [4:0]            dest_in,
    output logic                  ready_out,
    output logic [31:0]           valid_out,
    output logic [32*WIDTH-1:0]   data_out,
    input  logic [31:0]           ready_in
);

    logic                        s1_full;
    logic [4:0]                  s1_dest;
    logic [WIDTH-1:0]            s1_data;
    logic [31:0]                 full;
    logic [31:0][WIDTH-1:0]      port_dat;
    logic                        mv;
    logic                        up_xfer;
    logic [31:0]                 port_load;

    // The move only looks at S1 state and ready_in, so ready_out never depends on valid_in.
    assign mv        = s1_full && (!full[s1_dest] || ready_in[s1_dest]);
    assign ready_out = !s1_full || mv;
    assign up_xfer   = valid_in && ready_out;

    assign valid_out = full;
    assign data_out  = port_dat;

    // One-hot: at most one port register loads per cycle.
    always_comb begin
        port_load = '0;
        if (mv) begin
            port_load[s1_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_full <= 1'b0;
            s1_dest <= '0;
            s1_data <= '0;
        end else if (up_xfer) begin
            s1_full <= 1'b1;
            s1_dest <= dest_in;
            s1_data <= data_in;
        end else if (mv) begin
            s1_full <= 1'b0;
        end
    end

    // A load wins over a same-cycle drain, giving back-to-back beats on one port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full     <= '0;
            port_dat <= '0;
        end else begin
            for (int p = 0; p < 32; p++) begin
                if (port_load[p]) begin
                    full[p]     <= 1'b1;
                    port_dat[p] <= s1_data;
                end else if (full[p] && ready_in[p]) begin
                    full[p]     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/demux32_pipeline.md
DEMUX32_PIPELINE -- requirements
Module: demux32_pipeline

Interface
REQ-001 Parameter WIDTH, default 8, is the payload width in bits of every data beat (legal range 1..64).
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  is the reset: asynchronous, active-low. Low clears all state immediately; release is sampled on clk.
REQ-004 valid_in  input  1  means the upstream beat on data_in/dest_in is offered.
REQ-005 data_in  input  WIDTH  is the upstream payload.
REQ-006 dest_in  input  5  is the destination port index 0..31 for the offered beat.
REQ-007 ready_out  output  1  means the block accepts the upstream beat this cycle.
REQ-008 valid_out  output  32  bit p means port p offers a beat.
REQ-009 data_out  output  32*WIDTH  carries the port p payload in bits [(p+1)*WIDTH-1 : p*WIDTH].
REQ-010 ready_in  input  32  bit p means the port p consumer accepts this cycle.

Function
REQ-011 An upstream transfer occurs in a cycle with valid_in=1 and ready_out=1; a port p transfer occurs in a cycle with valid_out[p]=1 and ready_in[p]=1.
REQ-012 Stage S1 is a single-entry input register holding {dest, data} plus flag s1_full.
REQ-013 Stage S2 is 32 single-entry port registers, each holding data plus flag full[p]; valid_out[p]=full[p] and data_out slice p equals the register contents.
REQ-014 S1-to-S2 move (mv) is asserted when s1_full=1 and (full[d]=0 or ready_in[d]=1), with d = S1 dest.
REQ-015 ready_out = !s1_full | mv, combinational; there is no combinational path from valid_in to ready_out.
REQ-016 On an upstream transfer, S1 loads {dest_in, data_in} and s1_full is set; otherwise, on mv, s1_full is cleared.
REQ-017 On mv, port d loads the S1 data and full[d] is set, including when port d transfers in the same cycle (back-to-back).
REQ-018 Port p with no mv targeting it clears full[p] on a port p transfer.
REQ-019 Latency: a beat accepted at edge N is visible on valid_out[d] after edge N+1, provided port d is free.
REQ-020 Throughput: one beat per cycle sustained when destination ports drain every cycle, including repeated beats to the same port.
REQ-021 Blocking: when full[d]=1 and ready_in[d]=0, S1 holds, ready_out=0, and other ports still drain independently.
REQ-022 Ordering: beats to the same port leave in acceptance order; beats are never dropped or duplicated.
REQ-023 Stability: while valid_out[p]=1 and ready_in[p]=0, data_out slice p is held constant.
REQ-024 At most one port register loads per cycle; valid_out bits for non-destination ports are unaffected by mv.
REQ-025 Simultaneous upstream transfer and mv: S1 is replaced by the new beat, s1_full stays 1, and the old beat goes to port d.

Reset
REQ-026 While rst=0: s1_full=0, all full[p]=0, valid_out=32'h0, data_out=0, S1 contents=0, ready_out=1.
REQ-027 Reset mid-operation discards beats held in S1 and S2 without emitting them.
REQ-028 After rst rises, the first upstream transfer is accepted on the first clk edge with valid_in=1.

Verification
REQ-029 Reset: rst=0 with valid_in=1 -> valid_out=0 and ready_out=1; release rst, send data 8'hA5 to dest 3 -> valid_out[3]=1, data 8'hA5, two edges after the offer is first seen.
REQ-030 Streaming: 16 beats to dest 7, ready_in=all ones -> one beat per cycle on port 7, in order, ready_out constantly 1.
REQ-031 Backpressure: ready_in[5]=0, send beats to 5, 5, 9 -> first beat in port 5, second held in S1, ready_out=0, and the 9 beat not accepted; raise ready_in[5] -> beats emerge in order 5, 5, 9.
REQ-032 Independent drain: port 2 full and stalled, port 30 full with ready_in[30]=1 -> port 30 empties next cycle and port 2 data is unchanged.
REQ-033 Reset mid-flight: port 4 and S1 full, pulse rst low for one cycle between edges -> all valid_out=0 immediately and no stale beat appears afterward.
REQ-034 Random: 10k beats with random dest, valid_in and ready_in -> scoreboard shows per-port order preserved, no loss or duplication, and stability (REQ-023) holds.
